// File: rtl/inv_shift_rows_stage.sv
// Registered AES InvShiftRows stage with a 2-entry skid buffer (main reg M, skid reg S).
// Optional stall counter port enabled by defining INV_SR_STALL_CNT_EN.
module inv_shift_rows_stage #(
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       data_in,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       data_out,
  output logic [TAG_W-1:0]   tag_out
`ifdef INV_SR_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  logic [127:0]     perm;
  logic [127:0]     m_data_q, m_data_d, s_data_q, s_data_d;
  logic [TAG_W-1:0] m_tag_q, m_tag_d, s_tag_q, s_tag_d;
  logic             m_v_q, m_v_d, s_v_q, s_v_d;
  logic             acc, emi;

  // Byte i sits at row i%4, column i/4; out[r][c] = in[r][(c-r) mod 4].
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign perm[127-8*(r+4*c) -: 8] = data_in[127-8*(r+4*((c+4-r)%4)) -: 8];
    end
  end

  assign in_ready  = !s_v_q;
  assign out_valid = m_v_q;
  assign data_out  = m_data_q;
  assign tag_out   = m_tag_q;

  assign acc = in_valid & in_ready;
  assign emi = m_v_q & out_ready;

  always_comb begin
    m_v_d    = m_v_q;
    s_v_d    = s_v_q;
    m_data_d = m_data_q;
    m_tag_d  = m_tag_q;
    s_data_d = s_data_q;
    s_tag_d  = s_tag_q;
    if (flush) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (!m_v_q) begin
      if (acc) begin
        m_v_d    = 1'b1;
        m_data_d = perm;
        m_tag_d  = tag_in;
      end
    end else if (emi) begin
      if (s_v_q) begin
        m_data_d = s_data_q;
        m_tag_d  = s_tag_q;
        s_v_d    = 1'b0;
      end else if (acc) begin
        m_data_d = perm;
        m_tag_d  = tag_in;
      end else begin
        m_v_d = 1'b0;
      end
    end else if (acc) begin
      // M is stalled: park the new block in S, which drops in_ready next cycle.
      s_v_d    = 1'b1;
      s_data_d = perm;
      s_tag_d  = tag_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v_q    <= 1'b0;
      s_v_q    <= 1'b0;
      m_data_q <= '0;
      m_tag_q  <= '0;
      s_data_q <= '0;
      s_tag_q  <= '0;
    end else begin
      m_v_q    <= m_v_d;
      s_v_q    <= s_v_d;
      m_data_q <= m_data_d;
      m_tag_q  <= m_tag_d;
      s_data_q <= s_data_d;
      s_tag_q  <= s_tag_d;
    end
  end

`ifdef INV_SR_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush)
      stall_cnt_d = '0;
    else if (m_v_q && !out_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
// Scoreboard bench for inv_shift_rows_stage; inputs driven and outputs checked on the falling edge.
// Stall counter checks are included when INV_SR_STALL_CNT_EN is defined.
module tb_inv_shift_rows_stage;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_in = '0;
  logic [3:0]   tag_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] data_out;
  logic [3:0]   tag_out;
`ifdef INV_SR_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [131:0] sb[$];

  always #5 clk = ~clk;

  inv_shift_rows_stage #(.TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .tag_out   (tag_out)
`ifdef INV_SR_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: load 4x4 matrix, rotate row r right by r positions.
  function automatic logic [127:0] model(input logic [127:0] x);
    logic [7:0] m[4][4];
    logic [7:0] t;
    logic [127:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = x[127-8*(4*c+r) -: 8];
    for (int r = 1; r < 4; r++)
      for (int k = 0; k < r; k++) begin
        t = m[r][3];
        m[r][3] = m[r][2];
        m[r][2] = m[r][1];
        m[r][1] = m[r][0];
        m[r][0] = t;
      end
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = m[r][c];
    return y;
  endfunction

  // Called at a falling edge: drive inputs, score the coming edge, advance one cycle.
  task automatic step(input logic v, input logic [127:0] d, input logic [3:0] t,
                      input logic rdy, input logic fl);
    logic [131:0] e;
    in_valid  = v;
    data_in   = d;
    tag_in    = t;
    out_ready = rdy;
    flush     = fl;
    if (out_valid && rdy) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 132'd1, 132'd0);
      end else begin
        e = sb.pop_front();
        check("data", {4'h0, data_out}, {4'h0, e[127:0]});
        check("tag", {128'h0, tag_out}, {128'h0, e[131:128]});
      end
    end
    if (fl) sb.delete();
    else if (v && in_ready) sb.push_back({t, model(d)});
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drain();
    for (int i = 0; i < 8 && out_valid; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    check("drain_empty", {131'h0, out_valid}, 132'd0);
  endtask

  logic [127:0] hold_d;
  logic [3:0]   hold_t;

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", {131'h0, out_valid}, 132'd0);
    check("rst_data_out", {4'h0, data_out}, 132'd0);
    check("rst_tag_out", {128'h0, tag_out}, 132'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {131'h0, in_ready}, 132'd1);

    // Known-answer vector and single-cycle latency.
    step(1'b1, 128'h7ad5fda789ef4e272bca100b3d9ff59f, 4'd1, 1'b1, 1'b0);
    check("kat_valid", {131'h0, out_valid}, 132'd1);
    check("kat_data", {4'h0, data_out}, {4'h0, 128'h7a9f102789d5f50b2beffd9f3dca4ea7});
    check("kat_tag", {128'h0, tag_out}, 132'd1);
    drain();

    // Back-to-back 16 states at full rate.
    for (int i = 0; i < 16; i++) begin
      check("b2b_in_ready", {131'h0, in_ready}, 132'd1);
      step(1'b1, rnd128(), 4'(i), 1'b1, 1'b0);
      check("b2b_out_valid", {131'h0, out_valid}, 132'd1);
    end
    drain();

    // Backpressure: 3 offered, 2 accepted, outputs held.
    step(1'b1, rnd128(), 4'd3, 1'b0, 1'b0);
    hold_d = data_out;
    hold_t = tag_out;
    step(1'b1, rnd128(), 4'd4, 1'b0, 1'b0);
    check("bp_in_ready_low", {131'h0, in_ready}, 132'd0);
    step(1'b1, rnd128(), 4'd5, 1'b0, 1'b0);
    check("bp_in_ready_still_low", {131'h0, in_ready}, 132'd0);
    check("bp_hold_data", {4'h0, data_out}, {4'h0, hold_d});
    check("bp_hold_tag", {128'h0, tag_out}, {128'h0, hold_t});
    check("bp_sb_depth", 132'(sb.size()), 132'd2);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("bp_no_gap", {131'h0, out_valid}, 132'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("bp_empty", {131'h0, out_valid}, 132'd0);
    check("bp_in_ready_back", {131'h0, in_ready}, 132'd1);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), rnd128(), 4'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    drain();
    check("rand_sb_empty", 132'(sb.size()), 132'd0);

    // Flush with M and S full.
    step(1'b1, rnd128(), 4'd6, 1'b0, 1'b0);
    step(1'b1, rnd128(), 4'd7, 1'b0, 1'b0);
    check("fl_full", {131'h0, in_ready}, 132'd0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("fl_out_valid", {131'h0, out_valid}, 132'd0);
    check("fl_in_ready", {131'h0, in_ready}, 132'd1);
    // Flush discards a same-cycle accept.
    step(1'b1, rnd128(), 4'd8, 1'b0, 1'b1);
    check("fl_discard", {131'h0, out_valid}, 132'd0);

`ifdef INV_SR_STALL_CNT_EN
    check("sc_cleared", {116'h0, stall_cnt}, 132'd0);
    step(1'b1, rnd128(), 4'd9, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    check("sc_five", {116'h0, stall_cnt}, 132'd5);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("sc_flush", {116'h0, stall_cnt}, 132'd0);
`endif

    // Asynchronous reset mid-burst.
    step(1'b1, rnd128(), 4'd10, 1'b0, 1'b0);
    step(1'b1, rnd128(), 4'd11, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {131'h0, out_valid}, 132'd0);
    check("arst_data_out", {4'h0, data_out}, 132'd0);
    check("arst_tag_out", {128'h0, tag_out}, 132'd0);
    check("arst_in_ready", {131'h0, in_ready}, 132'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 128'h7ad5fda789ef4e272bca100b3d9ff59f, 4'd2, 1'b1, 1'b0);
    drain();
    check("final_sb_empty", 132'(sb.size()), 132'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
